// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier sequencer.
// Optional feature macro: MULT_SIGNED_EN (two's complement operands).
package mult_pkg;

  // Operand width used when the parent does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter must be able to hold the value WIDTH itself.
  function automatic int cntWidth(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_WIDTH = $clog2(DEFAULT_WIDTH + 1);

  // Sequencer states; FIX is only reachable when signed mode is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath: multiplicand register, accumulator, multiplier shift
// register and the WIDTH+1-bit adder that feeds the accumulator.
// Optional feature macro: MULT_SIGNED_EN (magnitude capture and final negate).
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
`ifdef MULT_SIGNED_EN
  input  logic               fix_i,
`endif
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplr_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mplr_q;
  logic [WIDTH-1:0] mcandMag;
  logic [WIDTH-1:0] mplrMag;
  logic [WIDTH:0]   sum;

`ifdef MULT_SIGNED_EN
  logic               neg_q;
  logic               negNext;
  logic [2*WIDTH-1:0] negResult;

  // Operands enter as magnitudes; the product sign is remembered separately.
  // The most negative value maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    mcandMag  = mcand_i[WIDTH-1] ? -mcand_i : mcand_i;
    mplrMag   = mplr_i[WIDTH-1]  ? -mplr_i  : mplr_i;
    negNext   = mcand_i[WIDTH-1] ^ mplr_i[WIDTH-1];
    negResult = -{acc_q, mplr_q};
  end
`else
  // Unsigned build: operands are captured unchanged.
  always_comb begin
    mcandMag = mcand_i;
    mplrMag  = mplr_i;
  end
`endif

  // The carry out of the add lands in the accumulator MSB after the shift.
  always_comb begin
    sum = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  end

  // Capture on load, one shift-add per step, optional negate in the fix cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else if (load_i) begin
      mcand_q <= mcandMag;
      acc_q   <= '0;
      mplr_q  <= mplrMag;
`ifdef MULT_SIGNED_EN
      neg_q   <= negNext;
`endif
    end else if (step_i) begin
      acc_q   <= sum[WIDTH:1];
      mplr_q  <= {sum[0], mplr_q[WIDTH-1:1]};
`ifdef MULT_SIGNED_EN
    end else if (fix_i && neg_q) begin
      {acc_q, mplr_q} <= negResult;
`endif
    end
  end

  assign result_o = {acc_q, mplr_q};

endmodule

// File: rtl/mult_sequencer.sv
// Sequential WIDTH x WIDTH multiplier: FSM, iteration counter and the
// registered product/valid/done outputs around the shift-add datapath.
// Optional feature macro: MULT_SIGNED_EN (signed operands, extra FIX cycle).
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   plicand,
  input  logic [WIDTH-1:0]   pliar,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               valid
);

  localparam int CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               doLoad;
  logic               doStep;
  logic [2*WIDTH-1:0] result;
`ifdef MULT_SIGNED_EN
  logic               doFix;
`endif

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (doLoad),
    .step_i   (doStep),
`ifdef MULT_SIGNED_EN
    .fix_i    (doFix),
`endif
    .mcand_i  (plicand),
    .mplr_i   (pliar),
    .result_o (result)
  );

  // Next-state, counter and output-register updates; start only counts in IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    doLoad    = 1'b0;
    doStep    = 1'b0;
`ifdef MULT_SIGNED_EN
    doFix     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          doLoad  = 1'b1;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        doStep = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
`ifdef MULT_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
      FIX: begin
`ifdef MULT_SIGNED_EN
        doFix   = 1'b1;
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        product_d = result;
        valid_d   = 1'b1;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter and output registers, all cleared by the async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;
  assign valid   = valid_q;

endmodule
